hilo_div_ctrl: RTL and testbench

- Sits in the EX stage between the pipeline and the 32-bit iterative divider.
- Accepts DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and latches the divide operands for the whole operation.
- Drives the divider handshake, stalls EX until the quotient and remainder land, and owns the architectural HI/LO registers.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_div_ctrl.sv | 103 ++++++++++
 tb/tb_hilo_div_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO / divider controller.
package hilo_pkg;

    localparam int HILO_W = 32;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        DIV  = 3'd1,
        DIVU = 3'd2,
        MTHI = 3'd3,
        MTLO = 3'd4,
        MFHI = 3'd5,
        MFLO = 3'd6
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } hilo_state_t;

    function automatic logic is_div_op(input hilo_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// EX-stage HI/LO owner and iterative-divider handshake controller.
// Optional: DIV_BYZERO_SKIP_EN retires divide-by-zero as a no-op.
module hilo_div_ctrl
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_W
) (
    input  logic              div_clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  hilo_op_t          ex_op,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic [DATA_W-1:0] ex_rt,
    input  logic              ex_flush,
    output logic              hilo_stall,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_req,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_x,
    output logic [DATA_W-1:0] div_y,
    input  logic [DATA_W-1:0] div_s,
    input  logic [DATA_W-1:0] div_r,
    input  logic              div_complete
);

    hilo_state_t       state_q;
    logic [DATA_W-1:0] hi_q, lo_q, x_q, y_q;
    logic              req_q, sgn_q;

    logic ex_div, div_go, mt_ok;

    assign ex_div = ex_valid && !ex_flush && is_div_op(ex_op);
`ifdef DIV_BYZERO_SKIP_EN
    assign div_go = ex_div && (ex_rt != '0);
`else
    assign div_go = ex_div;
`endif
    assign mt_ok  = ex_valid && !ex_flush && (state_q != BUSY);

    // In DRAIN any divide waits for IDLE so the divider sees complete low first.
    always_comb begin
        hilo_stall = 1'b0;
        unique case (state_q)
            IDLE:    hilo_stall = div_go;
            BUSY:    hilo_stall = !div_complete;
            DRAIN:   hilo_stall = ex_div;
            default: hilo_stall = 1'b0;
        endcase
    end

    assign mf_data    = (ex_op == MFHI) ? hi_q : lo_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign div_req    = req_q;
    assign div_signed = sgn_q;
    assign div_x      = x_q;
    assign div_y      = y_q;

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_go) begin
                        x_q     <= ex_rs;
                        y_q     <= ex_rt;
                        sgn_q   <= (ex_op == DIV);
                        req_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A flush wins over a same-cycle result: HI/LO stay architectural.
                    if (ex_flush) begin
                        req_q   <= 1'b0;
                        state_q <= DRAIN;
                    end else if (div_complete) begin
                        lo_q    <= div_s;
                        hi_q    <= div_r;
                        req_q   <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!div_complete) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (mt_ok && ex_op == MTHI) hi_q <= ex_rs;
            if (mt_ok && ex_op == MTLO) lo_q <= ex_rs;
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a behavioural 34-cycle divider.
module tb_hilo_div_ctrl;
    import hilo_pkg::*;

    localparam int LAT = 34;

    logic        div_clk = 1'b0;
    logic        resetn;
    logic        ex_valid;
    hilo_op_t    ex_op;
    logic [31:0] ex_rs, ex_rt;
    logic        ex_flush;
    logic        hilo_stall;
    logic [31:0] mf_data, hi, lo;
    logic        div_req, div_signed;
    logic [31:0] div_x, div_y;
    logic [31:0] div_s, div_r;
    logic        div_complete;

    int total = 0;
    int bad   = 0;
    int stall_bad, xy_bad;
    logic done;

    hilo_div_ctrl #(.DATA_W(32)) dut (
        .div_clk(div_clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_flush(ex_flush), .hilo_stall(hilo_stall), .mf_data(mf_data),
        .hi(hi), .lo(lo), .div_req(div_req), .div_signed(div_signed),
        .div_x(div_x), .div_y(div_y), .div_s(div_s), .div_r(div_r),
        .div_complete(div_complete)
    );

    always #5 div_clk = ~div_clk;

    // Divider: one-cycle complete pulse LAT cycles after req rises; aborts when req drops.
    int cnt;
    always @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 0; div_complete <= 1'b0; div_s <= '0; div_r <= '0;
        end else begin
            div_complete <= 1'b0;
            if (!div_req) cnt <= 0;
            else if (cnt == LAT-1) begin
                div_complete <= 1'b1;
                cnt <= LAT;
                if (div_y == 0) begin
                    div_s <= '1; div_r <= div_x;
                end else if (div_signed) begin
                    div_s <= $signed(div_x) / $signed(div_y);
                    div_r <= $signed(div_x) % $signed(div_y);
                end else begin
                    div_s <= div_x / div_y;
                    div_r <= div_x % div_y;
                end
            end else if (cnt < LAT) cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_op = NOP; ex_flush = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the result-writing edge.
    task automatic run_div(input hilo_op_t op, input logic [31:0] rs, input logic [31:0] rt);
        ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt; ex_flush = 1'b0;
        #1;
        stall_bad = 0; xy_bad = 0; done = 1'b0;
        if (!hilo_stall) stall_bad++;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge div_clk); #1;
            if (div_complete) begin
                done = 1'b1;
                if (hilo_stall) stall_bad++;
            end else begin
                if (!hilo_stall) stall_bad++;
                if (div_req && (div_x !== rs || div_y !== rt || div_signed !== (op == DIV)))
                    xy_bad++;
            end
        end
        chk("div_timeout", {31'd0, done}, 32'd1);
        @(negedge div_clk);
    endtask

    initial begin
        resetn = 1'b0; ex_rs = '0; ex_rt = '0;
        idle_in();
        repeat (3) @(negedge div_clk);
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_req", {31'd0, div_req}, 32'd0);
        chk("rst_sgn", {31'd0, div_signed}, 32'd0);
        chk("rst_x", div_x, 32'h0);
        chk("rst_y", div_y, 32'h0);
        chk("rst_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk);
        resetn = 1'b1;
        @(negedge div_clk);

        // signed -7/2
        run_div(DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_stall", stall_bad, 0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        ex_op = MFHI; #1;
        chk("mfhi_after_div", mf_data, 32'hFFFF_FFFF);
        chk("mfhi_drain_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk); idle_in();

        // unsigned 0xFFFFFFFF/16
        run_div(DIVU, 32'hFFFF_FFFF, 32'h10);
        chk("divu_xy_sgn", xy_bad, 0);
        chk("divu_stall", stall_bad, 0);
        chk("divu_lo", lo, 32'h0FFF_FFFF);
        chk("divu_hi", hi, 32'h0000_000F);
        idle_in();
        @(negedge div_clk);

        // MT then MF
        ex_valid = 1'b1; ex_op = MTHI; ex_rs = 32'h1234_5678; #1;
        chk("mthi_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk); ex_op = MFHI; #1;
        chk("mfhi", mf_data, 32'h1234_5678);
        chk("mfhi_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk); ex_op = MTLO; ex_rs = 32'hA5A5_A5A5;
        @(negedge div_clk); ex_op = MFLO; #1;
        chk("mflo", mf_data, 32'hA5A5_A5A5);
        chk("mflo_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk); idle_in();

        // flush on BUSY cycle 10
        ex_valid = 1'b1; ex_op = DIV; ex_rs = 32'd100; ex_rt = 32'd7;
        repeat (11) @(negedge div_clk);
        ex_flush = 1'b1;
        @(negedge div_clk);
        idle_in();
        chk("flush_req", {31'd0, div_req}, 32'd0);
        chk("flush_hi", hi, 32'h1234_5678);
        chk("flush_lo", lo, 32'hA5A5_A5A5);
        run_div(DIVU, 32'd9, 32'd4);
        chk("postflush_stall", stall_bad, 0);
        chk("postflush_lo", lo, 32'd2);
        chk("postflush_hi", hi, 32'd1);
        idle_in();
        @(negedge div_clk);

        // back-to-back: second DIVU presented in the DRAIN cycle
        run_div(DIV, 32'd100, 32'd7);
        chk("b2b_first_lo", lo, 32'd14);
        chk("b2b_first_hi", hi, 32'd2);
        run_div(DIVU, 32'd50, 32'd5);
        chk("b2b_stall", stall_bad, 0);
        chk("b2b_lo", lo, 32'd10);
        chk("b2b_hi", hi, 32'd0);
        idle_in();
        @(negedge div_clk);

        // async reset while BUSY
        ex_valid = 1'b1; ex_op = DIV; ex_rs = 32'd100; ex_rt = 32'd7;
        repeat (4) @(negedge div_clk);
        idle_in();
        #2 resetn = 1'b0;
        #1;
        chk("arst_req", {31'd0, div_req}, 32'd0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(negedge div_clk); resetn = 1'b1;
        @(negedge div_clk);

        // divide by zero
        ex_valid = 1'b1; ex_op = MTHI; ex_rs = 32'h55;
        @(negedge div_clk);
        ex_op = DIV; ex_rs = 32'd5; ex_rt = 32'd0; #1;
`ifdef DIV_BYZERO_SKIP_EN
        chk("dbz_stall", {31'd0, hilo_stall}, 32'd0);
        @(negedge div_clk); idle_in(); #1;
        chk("dbz_req", {31'd0, div_req}, 32'd0);
        chk("dbz_hi", hi, 32'h55);
        chk("dbz_lo", lo, 32'h0);
`else
        chk("dbz_stall", {31'd0, hilo_stall}, 32'd1);
        @(negedge div_clk); #1;
        chk("dbz_req", {31'd0, div_req}, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge div_clk);
            if (div_complete) done = 1'b1;
        end
        chk("dbz_timeout", {31'd0, done}, 32'd1);
        @(negedge div_clk); idle_in();
`endif
        repeat (3) @(negedge div_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
